clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Runtime-programmable integer clock divider producing a 50%-duty o_clk from sclk
//   for any divisor N >= 2, odd or even.
//   Successor to the fixed odd-N divider. Adds the following:
//   - run-time divisor load, applied only at period boundaries;
//   - enable with clean start and stop;
//   - an sclk-domain period tick.
//   Feeds slow peripheral clocks (UART/SPI/LED timing) and tick-driven logic.
// PARAMETERS
//   WIDTH        8   counter/divisor width; N range 2 .. 2**WIDTH-1
//   DIV_DEFAULT  5   divisor active out of reset; must be in 2 .. 2**WIDTH-1
// PORTS
//   sclk      in   1      source clock
//   rst_n     in   1      asynchronous, active-low reset
//   en        in   1      run request
//   div_load  in   1      strobe: capture div_val into shadow register
//   div_val   in   WIDTH  requested divisor; values 0/1 clamped to 2 at capture
//   o_clk     out  1      divided clock, 50% duty
//   o_tick    out  1      1-sclk pulse, high for the cycle in which cnt==0
//   div_cur   out  WIDTH  divisor of the period currently running
// BEHAVIOUR
//   Reset values
//   - cnt=0, run=0, clk_p=0, clk_n=0, odd=0, o_tick=0.
//   - div_cur=DIV_DEFAULT, shadow=DIV_DEFAULT, pend=0.
//   - o_clk=0 while in reset and until the first start.
//   Posedge domain
//   - cnt counts 0..div_cur-1. boundary = run & (cnt==div_cur-1).
//   - Start: when run==0 and en==1, the next posedge sets run=1, cnt=0, clk_p=1, o_tick=1.
//     Result: o_clk rises one posedge after en is sampled high.
//   - At a boundary:
//     * if pend, then div_cur<=shadow and odd<=shadow[0], and pend clears;
//     * if en==0, then run<=0 and cnt holds 0 (stop after a complete period);
//     * otherwise cnt<=0, clk_p<=1, o_tick<=1.
//   - clk_p is registered high while cnt < (div_cur>>1), low for the rest of the period.
//     clk_p is never high while run==0.
//   - div_load: shadow<=clamp(div_val), pend<=1.
//     A load in the same cycle as a boundary uses the new value at that boundary.
//     A repeated load before a boundary overwrites the shadow (last write wins).
//   Negedge domain
//   - clk_n <= clk_p & odd on each negedge (half-cycle retime).
//   Output
//   - o_clk = clk_p | clk_n.
//     * even N: high N/2 cycles, low N/2 cycles.
//     * odd N: high (N>>1)+0.5 cycles, low (N>>1)+0.5 cycles.
//   - odd changes only at a boundary, while clk_p=0 and clk_n=0.
//     Divisor and mode switches are therefore glitch-free and the last old period is always full.
//   - Latency from div_load to the new period is at most div_cur+1 sclk cycles.
//   - en toggling mid-period has no effect until the boundary. No runt pulses under any stimulus.
//   - Reset mid-operation forces o_clk low immediately (async). The restart needs en after release.
//   - div_cur is the maximum value (2**WIDTH-1): the counter never wraps past it.
//     The compare uses WIDTH bits; no carry-out is needed.
// STRUCTURE
//   - Shared header clk_div_defs.vh:
//     * DIV_MIN=2;
//     * the clamp function/macro;
//     * the duty-threshold expression (N>>1), reused by other divider variants.
//   - One sub-module, clk_div_negph: the negedge retime flop with async reset.
//     It isolates the only falling-edge logic for STA and lint waivers.
//   - The top holds the counter, shadow/pend, run control and tick.
// TESTING
//   1. Reset, en=1, default N=5 -> o_clk period 5 sclk, high 2.5 cycles.
//      o_tick every 5 cycles, aligned to the o_clk rise.
//   2. Load N=4 mid-period -> current 5-cycle period completes.
//      Then a 2-high/2-low pattern; div_cur changes to 4 exactly at the boundary.
//   3. Load 7 then 3 before a boundary -> next period is 3 (1.5 high/1.5 low).
//      Load 1 -> clamped to 2 (1 high/1 low).
//   4. en drops at cnt=1 of an N=6 period -> o_clk completes 3 high/3 low, then stays low.
//      en re-asserted -> o_clk rises one posedge later with o_tick.
//   5. Load coincident with a boundary (N 5->8) -> the 8-cycle period starts immediately.
//      Assert no glitch: o_clk has no pulse narrower than 0.5 sclk.
//   6. rst_n pulsed low mid-high-phase -> o_clk, o_tick low immediately.
//      div_cur=DIV_DEFAULT after release. WIDTH=4 with N=15 -> period 15 cycles, 7.5 high.

Source files
------------

// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable clock divider family.
// Holds the minimum legal divisor, the divisor clamp applied at capture and
// the duty threshold (N>>1) that sets where the high phase of a period ends.
// Helpers work on 32-bit values; callers size the result to their width.
package clk_div_prog_pkg;

   localparam logic [31:0] DIV_MIN = 32'd2;

   // Divisors below DIV_MIN cannot form a period with both phases present.
   function automatic logic [31:0] div_clamp(input logic [31:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

   // Number of whole sclk cycles the posedge phase stays high.
   function automatic logic [31:0] duty_thr(input logic [31:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clk_div_prog_negph.sv
// Falling-edge retime flop for the divider's odd-divisor half-cycle extension.
// This is the only negedge logic in the divider, kept apart so it is easy to
// find and constrain.
// Ports:
//   sclk  in  source clock (falling edge used)
//   rst_n in  asynchronous active-low reset
//   d     in  posedge-phase high qualified by odd mode
//   q     out d delayed by half an sclk cycle
module clk_div_negph (
   input  logic sclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for any N >= 2.
// A counter runs 0..div_cur-1; the posedge phase clk_p is high for the first
// N>>1 cycles, and for odd N a negedge copy stretches the high phase by half
// a cycle. New divisors and stop requests only take effect at the end of a
// complete period, so the output never produces a runt pulse.
// Ports:
//   sclk     in  source clock
//   rst_n    in  asynchronous active-low reset
//   en       in  run request (start on next posedge, stop at period end)
//   div_load in  strobe: capture div_val into the shadow divisor
//   div_val  in  requested divisor (0/1 clamp to 2)
//   o_clk    out divided clock
//   o_tick   out one-sclk pulse in the cnt==0 cycle
//   div_cur  out divisor of the running period
module clk_div_prog
   import clk_div_prog_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int unsigned DIV_DEFAULT = 5
) (
   input  logic             sclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   output logic             o_clk,
   output logic             o_tick,
   output logic [WIDTH-1:0] div_cur
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] next_div;
   logic [WIDTH-1:0] thr;
   logic             run;
   logic             clk_p;
   logic             clk_n;
   logic             odd;
   logic             pend;
   logic             pend_eff;
   logic             boundary;
   logic             neg_d;

   assign load_val = WIDTH'(div_clamp(32'(div_val)));
   assign thr      = WIDTH'(duty_thr(32'(div_cur)));
   // cnt never exceeds div_cur-1 <= 2**WIDTH-2, so the increment cannot wrap.
   assign cnt_inc  = cnt + WIDTH'(1);
   assign boundary = run && (cnt == div_cur - WIDTH'(1));

   // A load arriving in the boundary cycle itself is honoured at that boundary.
   assign next_div = div_load ? load_val : shadow;
   assign pend_eff = pend | div_load;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         run     <= 1'b0;
         clk_p   <= 1'b0;
         odd     <= 1'b0;
         o_tick  <= 1'b0;
         div_cur <= WIDTH'(DIV_DEFAULT);
         shadow  <= WIDTH'(DIV_DEFAULT);
         pend    <= 1'b0;
      end else begin
         if (div_load) begin
            shadow <= load_val;
            pend   <= 1'b1;
         end

         if (!run) begin
            cnt <= '0;
            if (en) begin
               // Both phases are low while idle, so odd can be aligned to the
               // running divisor here without disturbing o_clk.
               run    <= 1'b1;
               clk_p  <= 1'b1;
               o_tick <= 1'b1;
               odd    <= div_cur[0];
            end else begin
               clk_p  <= 1'b0;
               o_tick <= 1'b0;
            end
         end else if (boundary) begin
            // Both phases are low in the last cycle of a period, so swapping
            // the divisor and odd mode here cannot glitch o_clk.
            if (pend_eff) begin
               div_cur <= next_div;
               odd     <= next_div[0];
               pend    <= 1'b0;
            end
            cnt <= '0;
            if (en) begin
               clk_p  <= 1'b1;
               o_tick <= 1'b1;
            end else begin
               run    <= 1'b0;
               clk_p  <= 1'b0;
               o_tick <= 1'b0;
            end
         end else begin
            cnt    <= cnt_inc;
            clk_p  <= (cnt_inc < thr);
            o_tick <= 1'b0;
         end
      end
   end

   assign neg_d = clk_p & odd;

   clk_div_negph u_negph (
      .sclk  (sclk),
      .rst_n (rst_n),
      .d     (neg_d),
      .q     (clk_n)
   );

   assign o_clk = clk_p | clk_n;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

   logic       sclk;
   logic       rst_n;
   logic       en;
   logic       div_load;
   logic [7:0] div_val;
   logic       o_clk;
   logic       o_tick;
   logic [7:0] div_cur;

   logic       en4;
   logic       div_load4;
   logic [3:0] div_val4;
   logic       o_clk4;
   logic       o_tick4;
   logic [3:0] div_cur4;

   int total = 0;
   int bad   = 0;

   // pulse-width monitor on the main output
   int  glitches  = 0;
   time t_last    = 0;
   bit  have_last = 0;

   clk_div_prog #(.WIDTH(8), .DIV_DEFAULT(5)) dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .en       (en),
      .div_load (div_load),
      .div_val  (div_val),
      .o_clk    (o_clk),
      .o_tick   (o_tick),
      .div_cur  (div_cur)
   );

   clk_div_prog #(.WIDTH(4), .DIV_DEFAULT(15)) u_w4 (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .en       (en4),
      .div_load (div_load4),
      .div_val  (div_val4),
      .o_clk    (o_clk4),
      .o_tick   (o_tick4),
      .div_cur  (div_cur4)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   always @(o_clk) begin
      if (have_last && ($time - t_last < 5)) glitches++;
      t_last    = $time;
      have_last = 1'b1;
   end

   function automatic logic oc(input bit sel);
      return sel ? o_clk4 : o_clk;
   endfunction

   function automatic logic ot(input bit sel);
      return sel ? o_tick4 : o_tick;
   endfunction

   // advance to 1 ns after the next sclk edge of either polarity
   task automatic step;
      @(sclk);
      #1;
   endtask

   task automatic wait_rise(output bit to);
      int g;
      g = 0;
      while (o_clk == 1'b1 && g < 600) begin step; g++; end
      while (o_clk == 1'b0 && g < 600) begin step; g++; end
      to = (g >= 600);
   endtask

   // one full period measured in half-cycles, starting at the next rise
   task automatic measure(input bit sel, output int hi, output int lo,
                          output int ticks, output bit to);
      int g;
      g = 0; hi = 0; lo = 0; ticks = 0;
      while (oc(sel) == 1'b1 && g < 600) begin step; g++; end
      while (oc(sel) == 1'b0 && g < 600) begin step; g++; end
      to = (g >= 600);
      while (oc(sel) == 1'b1 && hi < 600) begin hi++; if (ot(sel)) ticks++; step; end
      while (oc(sel) == 1'b0 && lo < 600) begin lo++; if (ot(sel)) ticks++; step; end
   endtask

   task automatic wait_div_change(input logic [7:0] old, output int edges);
      edges = 0;
      do begin
         @(posedge sclk);
         #1;
         edges++;
      end while (div_cur === old && edges < 300);
   endtask

   task automatic test_reset;
      rst_n = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
      en4 = 1'b0; div_load4 = 1'b0; div_val4 = '0;
      #1 rst_n = 1'b0;
      #12;
      total++; if (o_clk !== 1'b0)   begin bad++; $display("FAIL reset_oclk: got %b want 0", o_clk); end
      total++; if (o_tick !== 1'b0)  begin bad++; $display("FAIL reset_tick: got %b want 0", o_tick); end
      total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL reset_div: got %0d want 5", div_cur); end
      total++; if (div_cur4 !== 4'd15) begin bad++; $display("FAIL reset_div4: got %0d want 15", div_cur4); end
      @(negedge sclk);
      rst_n = 1'b1;
      repeat (2) @(posedge sclk);
      #1;
      total++; if (o_clk !== 1'b0) begin bad++; $display("FAIL idle_oclk: got %b want 0", o_clk); end
   endtask

   task automatic test_default;
      int hi, lo, tk; bit to;
      @(negedge sclk);
      en = 1'b1;
      @(posedge sclk);
      #1;
      total++; if (o_clk !== 1'b1)  begin bad++; $display("FAIL start_oclk: got %b want 1", o_clk); end
      total++; if (o_tick !== 1'b1) begin bad++; $display("FAIL start_tick: got %b want 1", o_tick); end
      @(posedge sclk);
      #1;
      total++; if (o_tick !== 1'b0) begin bad++; $display("FAIL tick_width: got %b want 0", o_tick); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL n5_timeout: got %b want 0", to); end
      total++; if (hi !== 5) begin bad++; $display("FAIL n5_high: got %0d want 5 half-cycles", hi); end
      total++; if (lo !== 5) begin bad++; $display("FAIL n5_low: got %0d want 5 half-cycles", lo); end
      total++; if (tk !== 2) begin bad++; $display("FAIL n5_ticks: got %0d want 2 half-cycles", tk); end
   endtask

   task automatic test_load_mid;
      int hi, lo, tk, edges; bit to;
      wait_rise(to);
      @(negedge sclk);
      div_load = 1'b1; div_val = 8'd4;
      @(negedge sclk);
      div_load = 1'b0;
      total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL mid_hold: got %0d want 5", div_cur); end
      wait_div_change(8'd5, edges);
      total++; if (edges !== 4)      begin bad++; $display("FAIL mid_edges: got %0d want 4", edges); end
      total++; if (div_cur !== 8'd4) begin bad++; $display("FAIL mid_div: got %0d want 4", div_cur); end
      total++; if (o_tick !== 1'b1)  begin bad++; $display("FAIL mid_tick: got %b want 1", o_tick); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 4 || lo !== 4) begin bad++; $display("FAIL n4_shape: got %0d/%0d want 4/4", hi, lo); end
   endtask

   task automatic test_last_wins;
      int hi, lo, tk, edges; bit to;
      wait_rise(to);
      @(negedge sclk);
      div_load = 1'b1; div_val = 8'd7;
      @(negedge sclk);
      div_val = 8'd3;
      @(negedge sclk);
      div_load = 1'b0;
      wait_div_change(8'd4, edges);
      total++; if (edges !== 2)      begin bad++; $display("FAIL lw_edges: got %0d want 2", edges); end
      total++; if (div_cur !== 8'd3) begin bad++; $display("FAIL lw_div: got %0d want 3", div_cur); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 3 || lo !== 3) begin bad++; $display("FAIL n3_shape: got %0d/%0d want 3/3", hi, lo); end
      @(negedge sclk);
      div_load = 1'b1; div_val = 8'd1;
      @(negedge sclk);
      div_load = 1'b0;
      wait_div_change(8'd3, edges);
      total++; if (div_cur !== 8'd2) begin bad++; $display("FAIL clamp_div: got %0d want 2", div_cur); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 2 || lo !== 2) begin bad++; $display("FAIL n2_shape: got %0d/%0d want 2/2", hi, lo); end
   endtask

   task automatic test_stop_restart;
      int hi, lo, tk, edges, g, hcnt; bit to; time t_rise, t_fall;
      @(negedge sclk);
      div_load = 1'b1; div_val = 8'd6;
      @(negedge sclk);
      div_load = 1'b0;
      wait_div_change(8'd2, edges);
      total++; if (div_cur !== 8'd6) begin bad++; $display("FAIL n6_div: got %0d want 6", div_cur); end
      wait_rise(to);
      t_rise = $time;
      @(posedge sclk);
      #1;
      en = 1'b0;
      g = 0;
      while (o_clk == 1'b1 && g < 100) begin step; g++; end
      t_fall = $time;
      total++; if (t_fall - t_rise !== 30) begin bad++; $display("FAIL stop_high: got %0t want 30", t_fall - t_rise); end
      hcnt = 0; tk = 0;
      repeat (40) begin
         step;
         if (o_clk) hcnt++;
         if (o_tick) tk++;
      end
      total++; if (hcnt !== 0) begin bad++; $display("FAIL stop_low: got %0d high samples want 0", hcnt); end
      total++; if (tk !== 0)   begin bad++; $display("FAIL stop_tick: got %0d tick samples want 0", tk); end
      @(negedge sclk);
      en = 1'b1;
      #1;
      total++; if (o_clk !== 1'b0) begin bad++; $display("FAIL restart_pre: got %b want 0", o_clk); end
      @(posedge sclk);
      #1;
      total++; if (o_clk !== 1'b1 || o_tick !== 1'b1) begin bad++; $display("FAIL restart: got clk=%b tick=%b want 1/1", o_clk, o_tick); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 6 || lo !== 6) begin bad++; $display("FAIL n6_shape: got %0d/%0d want 6/6", hi, lo); end
   endtask

   task automatic test_coincident;
      int hi, lo, tk, edges; bit to;
      @(negedge sclk);
      div_load = 1'b1; div_val = 8'd5;
      @(negedge sclk);
      div_load = 1'b0;
      wait_div_change(8'd6, edges);
      total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL co_pre: got %0d want 5", div_cur); end
      wait_rise(to);
      repeat (4) @(posedge sclk);
      #1;
      div_load = 1'b1; div_val = 8'd8;
      @(posedge sclk);
      #1;
      div_load = 1'b0;
      total++; if (div_cur !== 8'd8) begin bad++; $display("FAIL co_div: got %0d want 8", div_cur); end
      total++; if (o_clk !== 1'b1 || o_tick !== 1'b1) begin bad++; $display("FAIL co_start: got clk=%b tick=%b want 1/1", o_clk, o_tick); end
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 8 || lo !== 8) begin bad++; $display("FAIL n8_shape: got %0d/%0d want 8/8", hi, lo); end
      total++; if (glitches !== 0) begin bad++; $display("FAIL glitch: got %0d narrow pulses want 0", glitches); end
   endtask

   task automatic test_reset_mid;
      int hi, lo, tk; bit to;
      wait_rise(to);
      @(negedge sclk);
      #2;
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (o_clk !== 1'b0)   begin bad++; $display("FAIL rmid_oclk: got %b want 0", o_clk); end
      total++; if (o_tick !== 1'b0)  begin bad++; $display("FAIL rmid_tick: got %b want 0", o_tick); end
      total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL rmid_div: got %0d want 5", div_cur); end
      @(negedge sclk);
      rst_n = 1'b1;
      repeat (3) @(posedge sclk);
      #1;
      total++; if (o_clk !== 1'b0) begin bad++; $display("FAIL rmid_norestart: got %b want 0", o_clk); end
      @(negedge sclk);
      en = 1'b1;
      measure(1'b0, hi, lo, tk, to);
      total++; if (hi !== 5 || lo !== 5) begin bad++; $display("FAIL rmid_shape: got %0d/%0d want 5/5", hi, lo); end
   endtask

   task automatic test_width4;
      int hi, lo, tk; bit to;
      total++; if (div_cur4 !== 4'd15) begin bad++; $display("FAIL w4_div: got %0d want 15", div_cur4); end
      @(negedge sclk);
      en4 = 1'b1;
      measure(1'b1, hi, lo, tk, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL w4_timeout: got %b want 0", to); end
      total++; if (hi !== 15 || lo !== 15) begin bad++; $display("FAIL w4_shape: got %0d/%0d want 15/15", hi, lo); end
      total++; if (tk !== 2) begin bad++; $display("FAIL w4_ticks: got %0d want 2", tk); end
   endtask

   initial begin
      test_reset;
      test_default;
      test_load_mid;
      test_last_wins;
      test_stop_restart;
      test_coincident;
      test_reset_mid;
      test_width4;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
